// File: rtl/rr_log_packer_pkg.sv
// Shared fpgarr record types.
// Holds the AXI-Lite record widths used by the other recorders and the
// derivation of the logging-bus record width and beat count used by
// rr_log_packer. The packer FSM state type lives here as well.
package rr_log_packer_pkg;

  // AXI-Lite channel record widths (payload plus per-channel sideband)
  localparam int unsigned AXIL_ADDR_W   = 32;
  localparam int unsigned AXIL_DATA_W   = 32;
  localparam int unsigned AXIL_STRB_W   = AXIL_DATA_W / 8;
  localparam int unsigned AXIL_AW_REC_W = AXIL_ADDR_W + 3;
  localparam int unsigned AXIL_W_REC_W  = AXIL_DATA_W + AXIL_STRB_W;
  localparam int unsigned AXIL_B_REC_W  = 2;
  localparam int unsigned AXIL_AR_REC_W = AXIL_ADDR_W + 3;
  localparam int unsigned AXIL_R_REC_W  = AXIL_DATA_W + 2;

  // Logging-bus record: {loge_valid, logb_valid, logb_data}, data at LSBs
  function automatic int unsigned logb_rec_width(
    input int unsigned loge_cnt,
    input int unsigned logb_cnt,
    input int unsigned logb_data_w
  );
    return loge_cnt + logb_cnt + logb_data_w;
  endfunction

  // Beats needed to carry one record over an out_w-wide stream
  function automatic int unsigned logb_beat_count(
    input int unsigned rec_w,
    input int unsigned out_w
  );
    return (rec_w + out_w - 1) / out_w;
  endfunction

  typedef enum logic [0:0] {
    PK_IDLE = 1'b0,
    PK_SEND = 1'b1
  } packer_state_e;

endpackage

// File: rtl/rr_sync_fifo.sv
// Single-clock record buffer.
// Ports:
//   clk, sync_rst      clock, synchronous active-high reset
//   wr_en, wr_data     write request; ignored while full (a same-cycle pop
//                      does not make room)
//   rd_en, rd_data     pop request; rd_data shows the head entry (no bypass
//                      from a same-cycle write)
//   count, full, empty occupancy status
module rr_sync_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     sync_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_wr = wr_en && !full && !sync_rst;
  assign w_rd = rd_en && !empty && !sync_rst;

  assign rd_data = r_mem[r_rd_ptr];

  // Pointers are AW bits wide, so increment wraps modulo DEPTH
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rr_log_packer.sv
// Logging-bus record packer.
// Captures one record per cycle in which any logb/loge flag is set, buffers
// it, and serializes each record LSB-slice-first as NBEATS beats on a
// valid/ready stream.
// Ports:
//   clk, sync_rst     clock, synchronous active-high reset
//   logb_valid        per-channel data valid
//   logb_data         concatenated channel data, channel 0 at LSBs
//   loge_valid        per-channel end-of-transaction flags
//   logb_almful       registered backpressure to the recorders
//   out_valid/ready   beat handshake
//   out_data          beat data
//   out_last          final beat of a record
//   overflow          sticky, set when a record is dropped
module rr_log_packer
  import rr_log_packer_pkg::*;
#(
  parameter int unsigned LOGB_CHANNEL_CNT = 2,
  parameter int unsigned LOGB_DATA_WIDTH  = 36,
  parameter int unsigned LOGE_CHANNEL_CNT = 5,
  parameter int unsigned OUT_WIDTH        = 16,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned ALMFUL_MARGIN    = 4
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic [LOGB_CHANNEL_CNT-1:0] logb_valid,
  input  logic [LOGB_DATA_WIDTH-1:0]  logb_data,
  input  logic [LOGE_CHANNEL_CNT-1:0] loge_valid,
  output logic                        logb_almful,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_last,
  output logic                        overflow
);

  localparam int unsigned REC_W  = logb_rec_width(LOGE_CHANNEL_CNT, LOGB_CHANNEL_CNT,
                                                  LOGB_DATA_WIDTH);
  localparam int unsigned NBEATS = logb_beat_count(REC_W, OUT_WIDTH);
  localparam int unsigned PAD_W  = NBEATS * OUT_WIDTH;
  localparam int unsigned CH_W   = LOGB_DATA_WIDTH / LOGB_CHANNEL_CNT;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] ALMFUL_TH = CW'(DEPTH - ALMFUL_MARGIN);
  localparam logic [BW-1:0] LAST_IDX  = BW'(NBEATS - 1);

  packer_state_e r_state;
  packer_state_e w_state_nxt;
  logic [BW-1:0] r_beat_idx;
  logic          r_almful;
  logic          r_overflow;

  logic [LOGB_DATA_WIDTH-1:0] w_masked;
  logic [REC_W-1:0]           w_record;
  logic [REC_W-1:0]           w_rd_data;
  logic [PAD_W-1:0]           w_rd_pad;
  logic [OUT_WIDTH-1:0]       w_beat;
  logic [CW-1:0]              w_count;
  logic [CW-1:0]              w_count_nxt;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_cap;
  logic                       w_wr_ok;
  logic                       w_hs;
  logic                       w_last;
  logic                       w_pop;

  // Data of channels whose valid is low is stored as zero
  always_comb begin
    w_masked = '0;
    for (int unsigned c = 0; c < LOGB_CHANNEL_CNT; c++) begin
      if (logb_valid[c]) w_masked[c*CH_W +: CH_W] = logb_data[c*CH_W +: CH_W];
    end
  end

  assign w_record = {loge_valid, logb_valid, w_masked};
  assign w_cap    = ((|logb_valid) || (|loge_valid)) && !sync_rst;
  assign w_wr_ok  = w_cap && !w_full;

  rr_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .wr_en    (w_cap),
    .wr_data  (w_record),
    .rd_en    (w_pop),
    .rd_data  (w_rd_data),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_hs   = (r_state == PK_SEND) && out_ready;
  assign w_last = (r_beat_idx == LAST_IDX);
  assign w_pop  = w_hs && w_last;

  always_comb begin
    case ({w_wr_ok, w_pop})
      2'b10:   w_count_nxt = w_count + CW'(1);
      2'b01:   w_count_nxt = w_count - CW'(1);
      default: w_count_nxt = w_count;
    endcase
  end

  // IDLE leaves on the next-cycle occupancy (not the current count) so a
  // record written into an empty buffer is presented the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PK_IDLE: if (!w_empty || w_wr_ok) w_state_nxt = PK_SEND;
      PK_SEND: if (w_pop && (w_count_nxt == '0)) w_state_nxt = PK_IDLE;
      default: w_state_nxt = PK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state    <= PK_IDLE;
      r_beat_idx <= '0;
      r_almful   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_almful <= (w_count_nxt >= ALMFUL_TH);
      if (w_cap && w_full) r_overflow <= 1'b1;
      if (w_hs) r_beat_idx <= w_last ? '0 : r_beat_idx + 1'b1;
    end
  end

  assign w_rd_pad = PAD_W'(w_rd_data);

  always_comb begin
    w_beat = '0;
    for (int unsigned b = 0; b < NBEATS; b++) begin
      if (r_beat_idx == BW'(b)) w_beat = w_rd_pad[b*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign out_valid   = (r_state == PK_SEND);
  assign out_data    = out_valid ? w_beat : '0;
  assign out_last    = out_valid && w_last;
  assign logb_almful = r_almful;
  assign overflow    = r_overflow;

endmodule
